// File: rtl/key_op_queue.sv
// key_op_queue: edge-detected key capture with typematic repeat into a small FIFO of operations
module key_op_queue #(
  parameter int CODE_W        = 5,
  parameter int DEPTH         = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       keyReady,
  input  logic [CODE_W-1:0]          keyCode,
  input  logic                       repeat_en,
  input  logic                       op_ack,
  input  logic                       ovf_clr,
  output logic [CODE_W-1:0]          op,
  output logic                       op_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RMAX  = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W  = $clog2(RMAX + 1);
  localparam logic [RC_W-1:0] DLY = RC_W'(REPEAT_DELAY);
  localparam logic [RC_W-1:0] PER = RC_W'(REPEAT_PERIOD);

  logic              was_q, rpt_q, rpt_d, ovf_q, ovf_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] mem [DEPTH];
  logic              press, hit, rep, push, pop, full, accept, drop, hold;

  // Press/repeat detection, FIFO bookkeeping and sticky overflow next-state.
  // The repeat counter counts the initial delay first (rpt_q=0), then restarts
  // at 1 for each period (rpt_q=1), which keeps it valid for any delay/period ratio.
  always_comb begin
    press    = keyReady & ~was_q;
    hold     = keyReady & repeat_en;
    hit      = rc_q == (rpt_q ? PER : DLY);
    rep      = hold & ~press & hit;
    rc_d     = !hold ? '0 : (press || hit) ? RC_W'(1) : rc_q + RC_W'(1);
    rpt_d    = (!hold || press) ? 1'b0 : hit ? 1'b1 : rpt_q;
    push     = press | rep;
    pop      = op_ack & (cnt_q != '0);
    full     = cnt_q == CNT_W'(DEPTH);
    accept   = push & (~full | pop);
    drop     = push & full & ~pop;
    wr_d     = wr_q + PTR_W'(accept);
    rd_d     = rd_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(accept) - CNT_W'(pop);
    ovf_d    = drop | (ovf_q & ~ovf_clr);
    op_valid = cnt_q != '0;
    op       = op_valid ? mem[rd_q] : '0;
    count    = cnt_q;
    overflow = ovf_q;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      was_q <= 1'b0;
      rpt_q <= 1'b0;
      rc_q  <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      was_q <= keyReady;
      rpt_q <= rpt_d;
      rc_q  <= rc_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage needs no reset; op is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_q] <= keyCode;
  end
endmodule

// File: tb/tb_key_op_queue.sv
// tb_key_op_queue: directed checks of capture, ordering, overflow and auto-repeat
module tb_key_op_queue;
  logic       clk = 1'b0;
  logic       rst, keyReady, repeat_en, op_ack, ovf_clr;
  logic [4:0] keyCode, op;
  logic       op_valid, overflow;
  logic [2:0] count;
  int         total = 0, bad = 0;
  logic [31:0] hits;

  key_op_queue #(.CODE_W(5), .DEPTH(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .keyReady(keyReady), .keyCode(keyCode), .repeat_en(repeat_en),
    .op_ack(op_ack), .ovf_clr(ovf_clr), .op(op), .op_valid(op_valid), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] code);
    keyCode  = code;
    keyReady = 1'b1;
    tick();
    keyReady = 1'b0;
    tick();
  endtask

  task automatic pop_expect(input string tag, input logic [4:0] code);
    chk(tag, 32'(op), 32'(code));
    op_ack = 1'b1;
    tick();
    op_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; keyReady = 1'b1; keyCode = 5'h0A; repeat_en = 1'b0; op_ack = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(op_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_op", 32'(op), 0);
    rst = 1'b0;
    tick();
    chk("rel_valid", 32'(op_valid), 1);
    chk("rel_op", 32'(op), 32'h0A);
    keyReady = 1'b0; op_ack = 1'b1;
    tick();
    op_ack = 1'b0;
    chk("rel_drain", 32'(count), 0);

    keyCode = 5'h03; keyReady = 1'b1;
    tick();
    chk("single_op", 32'(op), 3);
    chk("single_valid", 32'(op_valid), 1);
    chk("single_count", 32'(count), 1);
    tick();
    chk("hold_no_retrig", 32'(count), 1);
    keyReady = 1'b0; op_ack = 1'b1;
    tick();
    op_ack = 1'b0;
    chk("single_ack_valid", 32'(op_valid), 0);
    chk("single_ack_count", 32'(count), 0);

    for (int i = 1; i <= 4; i++) press(5'(i));
    chk("burst_count", 32'(count), 4);
    chk("burst_ovf", 32'(overflow), 0);
    press(5'h05);
    chk("full_ovf", 32'(overflow), 1);
    chk("full_count", 32'(count), 4);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);
    for (int i = 1; i <= 4; i++) pop_expect("burst_pop", 5'(i));
    chk("burst_empty", 32'(op_valid), 0);

    for (int i = 1; i <= 4; i++) press(5'(i));
    keyCode = 5'h09; keyReady = 1'b1; op_ack = 1'b1;
    tick();
    keyReady = 1'b0; op_ack = 1'b0;
    chk("fullack_count", 32'(count), 4);
    chk("fullack_ovf", 32'(overflow), 0);
    pop_expect("fullack_pop", 5'h02);
    pop_expect("fullack_pop", 5'h03);
    pop_expect("fullack_pop", 5'h04);
    pop_expect("fullack_pop", 5'h09);
    chk("fullack_empty", 32'(count), 0);
    tick();

    keyCode = 5'h07; repeat_en = 1'b1; op_ack = 1'b1; hits = '0;
    for (int k = 0; k < 26; k++) begin
      keyReady = k < 19;
      tick();
      hits[k] = op_valid && op == 5'h07;
    end
    chk("repeat_hits", hits, 32'h0001_1101);
    chk("repeat_ovf", 32'(overflow), 0);

    hits = '0;
    for (int k = 0; k < 26; k++) begin
      keyReady  = k < 19;
      repeat_en = k < 10;
      tick();
      hits[k] = op_valid && op == 5'h07;
    end
    chk("repeat_drop_hits", hits, 32'h0000_0101);
    keyReady = 1'b0;

    repeat (5) tick();
    chk("empty_ack_count", 32'(count), 0);
    chk("empty_ack_valid", 32'(op_valid), 0);
    op_ack = 1'b0;
    keyCode = 5'h15; keyReady = 1'b1;
    tick();
    keyReady = 1'b0;
    chk("after_empty_op", 32'(op), 32'h15);
    chk("after_empty_count", 32'(count), 1);
    tick();

    press(5'h11); press(5'h12); press(5'h13);
    keyCode = 5'h1F; keyReady = 1'b1; ovf_clr = 1'b1;
    tick();
    keyReady = 1'b0; ovf_clr = 1'b0;
    chk("set_wins_ovf", 32'(overflow), 1);
    chk("set_wins_count", 32'(count), 4);
    pop_expect("drop_pop", 5'h15);
    pop_expect("drop_pop", 5'h11);
    pop_expect("drop_pop", 5'h12);
    pop_expect("drop_pop", 5'h13);
    chk("drop_empty", 32'(op_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
